// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit: forwarding selects, stage tags and
// the hazard/forwarding match helpers used by pipe_hazard_unit.
package hazard_pkg;

  // Tags are stored at RV32I width; narrower register files are zero-extended.
  localparam int unsigned REG_AW_MAX = 5;

  localparam logic [REG_AW_MAX-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  ld;
    logic [REG_AW_MAX-1:0] rd;
  } stage_tag_t;

  localparam stage_tag_t TAG_BUBBLE = '0;

  function automatic logic fwd_hit(input stage_tag_t t, input logic [REG_AW_MAX-1:0] src);
    return t.valid & t.we & (t.rd == src);
  endfunction

  function automatic logic load_hz(input stage_tag_t t,
                                   input logic u1, input logic [REG_AW_MAX-1:0] s1,
                                   input logic u2, input logic [REG_AW_MAX-1:0] s2);
    return t.valid & t.we & t.ld & (t.rd != REG_X0) &
           ((u1 & (t.rd == s1)) | (u2 & (t.rd == s2)));
  endfunction

  function automatic fwd_sel_t fwd_pick(input logic use_src, input logic [REG_AW_MAX-1:0] src,
                                        input stage_tag_t mem, input stage_tag_t wb);
    if (!use_src || src == REG_X0) return FWD_RF;
    else if (fwd_hit(mem, src))     return FWD_MEM;
    else if (fwd_hit(wb, src))      return FWD_WB;
    else                            return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter for hazard statistics; synchronous active-high reset.
module hazard_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline: tracks EX/MEM/WB tags,
// drives forwarding selects, load-use stalls, branch flushes and mem_wait freeze.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module pipe_hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              ex_branch_taken,
  input  logic              mem_wait,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex_mem,
  output logic              flush_id,
  output logic              flush_ex,
  output fwd_sel_t          fwd_a_sel,
  output fwd_sel_t          fwd_b_sel,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt
);

  stage_tag_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [REG_AW_MAX-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic ex_use1_q, ex_use1_d, ex_use2_q, ex_use2_d;

  logic [REG_AW_MAX-1:0] id_rs1_w, id_rs2_w, id_rd_w;
  logic hz_ex, hz_mem, lu_stall, br_flush, issue;

  assign id_rs1_w = REG_AW_MAX'(id_rs1);
  assign id_rs2_w = REG_AW_MAX'(id_rs2);
  assign id_rd_w  = REG_AW_MAX'(id_rd);

  always_comb begin
    hz_ex    = load_hz(ex_q, id_use_rs1, id_rs1_w, id_use_rs2, id_rs2_w);
    hz_mem   = (LOAD_BUBBLES == 2) ? load_hz(mem_q, id_use_rs1, id_rs1_w, id_use_rs2, id_rs2_w)
                                   : 1'b0;
    lu_stall = hz_ex | hz_mem;
    br_flush = ex_branch_taken & ~mem_wait;
    // A taken branch squashes ID, so a conflicting ID instruction never issues.
    issue    = id_valid & ~mem_wait & ~ex_branch_taken & ~lu_stall;
  end

  always_comb begin
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_ex_mem = 1'b0;
    flush_id     = 1'b0;
    flush_ex     = 1'b0;
    if (mem_wait) begin
      stall_if     = 1'b1;
      stall_id     = 1'b1;
      stall_ex_mem = 1'b1;
    end else if (br_flush) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (lu_stall) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
  end

  always_comb begin
    ex_d      = ex_q;
    mem_d     = mem_q;
    wb_d      = wb_q;
    ex_rs1_d  = ex_rs1_q;
    ex_rs2_d  = ex_rs2_q;
    ex_use1_d = ex_use1_q;
    ex_use2_d = ex_use2_q;
    if (!mem_wait) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (issue) begin
        ex_d      = '{valid: 1'b1, we: id_reg_write, ld: id_is_load, rd: id_rd_w};
        ex_rs1_d  = id_rs1_w;
        ex_rs2_d  = id_rs2_w;
        ex_use1_d = id_use_rs1;
        ex_use2_d = id_use_rs2;
      end else begin
        ex_d      = TAG_BUBBLE;
        ex_rs1_d  = REG_X0;
        ex_rs2_d  = REG_X0;
        ex_use1_d = 1'b0;
        ex_use2_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= TAG_BUBBLE;
      mem_q     <= TAG_BUBBLE;
      wb_q      <= TAG_BUBBLE;
      ex_rs1_q  <= REG_X0;
      ex_rs2_q  <= REG_X0;
      ex_use1_q <= 1'b0;
      ex_use2_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      ex_rs1_q  <= ex_rs1_d;
      ex_rs2_q  <= ex_rs2_d;
      ex_use1_q <= ex_use1_d;
      ex_use2_q <= ex_use2_d;
    end
  end

  assign fwd_a_sel = fwd_pick(ex_use1_q, ex_rs1_q, mem_q, wb_q);
  assign fwd_b_sel = fwd_pick(ex_use2_q, ex_rs2_q, mem_q, wb_q);

`ifdef HAZARD_PERF_EN
  logic stall_evt;
  assign stall_evt = lu_stall & ~mem_wait & ~br_flush;

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stall_evt),
    .cnt_o (perf_stall_cnt)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (br_flush),
    .cnt_o (perf_flush_cnt)
  );
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: two instances (LOAD_BUBBLES 1 and 2) share stimulus;
// expected output vectors are queued per cycle and compared per scenario.
module tb_pipe_hazard_unit;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_load;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic ex_branch_taken, mem_wait;

  logic sif_a, sid_a, sem_a, fid_a, fex_a, sif_b, sid_b, sem_b, fid_b, fex_b;
  logic [1:0] fa_a, fb_a, fa_b, fb_b;
  logic [3:0] pst_a, pfl_a, pst_b, pfl_b;
  logic [8:0] va, vb;

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] Z        = 9'b00000_00_00;
  localparam logic [8:0] STL      = 9'b11001_00_00;
  localparam logic [8:0] BRF      = 9'b00011_00_00;
  localparam logic [8:0] FA_MEM   = 9'b00000_10_00;
  localparam logic [8:0] FA_WB    = 9'b00000_01_00;
  localparam logic [8:0] FAB_WB   = 9'b00000_01_01;
  localparam logic [8:0] FAB_MEM  = 9'b00000_10_10;
  localparam logic [8:0] WAIT0    = 9'b11100_00_00;
  localparam logic [8:0] WAIT_MEM = 9'b11100_10_00;
  localparam logic [8:0] BR_MEM   = 9'b00011_10_00;

  typedef struct {
    string      tag;
    logic [8:0] ea;
    logic [8:0] eb;
  } exp_t;

  exp_t        expq[$];
  logic [17:0] obsq[$];

  always #5 clk = ~clk;

  pipe_hazard_unit #(.REG_AW(5), .LOAD_BUBBLES(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
    .stall_if(sif_a), .stall_id(sid_a), .stall_ex_mem(sem_a), .flush_id(fid_a),
    .flush_ex(fex_a), .fwd_a_sel(fa_a), .fwd_b_sel(fb_a),
    .perf_stall_cnt(pst_a), .perf_flush_cnt(pfl_a)
  );

  pipe_hazard_unit #(.REG_AW(5), .LOAD_BUBBLES(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
    .stall_if(sif_b), .stall_id(sid_b), .stall_ex_mem(sem_b), .flush_id(fid_b),
    .flush_ex(fex_b), .fwd_a_sel(fa_b), .fwd_b_sel(fb_b),
    .perf_stall_cnt(pst_b), .perf_flush_cnt(pfl_b)
  );

  assign va = {sif_a, sid_a, sem_a, fid_a, fex_a, fa_a, fb_a};
  assign vb = {sif_b, sid_b, sem_b, fid_b, fex_b, fa_b, fb_b};

  // A load still in MEM must never be the forwarding source for EX.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ((dut_a.mem_q.valid && dut_a.mem_q.ld && (fa_a == 2'b10 || fb_a == 2'b10)) ||
          (dut_b.mem_q.valid && dut_b.mem_q.ld && (fa_b == 2'b10 || fb_b == 2'b10))) begin
        errors++;
        $display("FAIL load_in_mem_fwd: fwd a=%b/%b b=%b/%b required no FWD_MEM from a load",
                 fa_a, fb_a, fa_b, fb_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic we, input logic ld);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = we; id_is_load = ld;
  endtask

  task automatic idle_id();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Inputs are applied just after posedge; outputs are sampled at negedge.
  task automatic cycle(input string tag, input logic chk, input logic [8:0] ea, input logic [8:0] eb);
    if (chk) expq.push_back('{tag, ea, eb});
    @(negedge clk);
    if (chk) obsq.push_back({va, vb});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle_id();
    ex_branch_taken = 1'b0;
    mem_wait = 1'b0;
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, Z, Z);
  endtask

  task automatic test_reset();
    exp_t e; logic [17:0] o;
    rst = 1'b1; idle_id(); ex_branch_taken = 1'b0; mem_wait = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    cycle("reset_idle", 1'b1, Z, Z);
    while (expq.size() != 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== {e.ea, e.eb}) begin
        errors++;
        $display("FAIL %s: got a=%b b=%b, expected a=%b b=%b", e.tag, o[17:9], o[8:0], e.ea, e.eb);
      end
    end
  endtask

  task automatic test_forwarding();
    exp_t e; logic [17:0] o;
    drain();
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0); cycle("fwdmem_c1", 1'b1, Z, Z);
    set_id(1, 5'd5, 1, 5'd3, 1, 5'd6, 1, 0); cycle("fwdmem_c2", 1'b1, Z, Z);
    idle_id();                               cycle("fwdmem_ex", 1'b1, FA_MEM, FA_MEM);
    drain();
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);    cycle("fwdwb_c1", 1'b1, Z, Z);
    set_id(1, 5'd10, 1, 5'd11, 1, 5'd9, 1, 0);  cycle("fwdwb_c2", 1'b1, Z, Z);
    set_id(1, 5'd5, 1, 5'd3, 1, 5'd6, 1, 0);    cycle("fwdwb_c3", 1'b1, Z, Z);
    idle_id();                                  cycle("fwdwb_ex", 1'b1, FA_WB, FA_WB);
    while (expq.size() != 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== {e.ea, e.eb}) begin
        errors++;
        $display("FAIL %s: got a=%b b=%b, expected a=%b b=%b", e.tag, o[17:9], o[8:0], e.ea, e.eb);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [17:0] o;
    drain();
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0); cycle("b2b_c1", 1'b1, Z, Z);
    set_id(1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0); cycle("b2b_c2", 1'b1, Z, Z);
    set_id(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0); cycle("b2b_c3", 1'b1, Z, Z);
    idle_id();                               cycle("b2b_mem_beats_wb", 1'b1, FAB_MEM, FAB_MEM);
    while (expq.size() != 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== {e.ea, e.eb}) begin
        errors++;
        $display("FAIL %s: got a=%b b=%b, expected a=%b b=%b", e.tag, o[17:9], o[8:0], e.ea, e.eb);
      end
    end
  endtask

  task automatic test_load_use();
    exp_t e; logic [17:0] o;
    drain();
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1); cycle("lu_lw", 1'b1, Z, Z);
    set_id(1, 5'd6, 1, 5'd6, 1, 5'd7, 1, 0); cycle("lu_stall1", 1'b1, STL, STL);
    cycle("lu_stall2", 1'b1, Z, STL);
    cycle("lu_fwd", 1'b1, FAB_WB, Z);
    idle_id(); cycle("lu_after", 1'b1, Z, Z);
    while (expq.size() != 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== {e.ea, e.eb}) begin
        errors++;
        $display("FAIL %s: got a=%b b=%b, expected a=%b b=%b", e.tag, o[17:9], o[8:0], e.ea, e.eb);
      end
    end
  endtask

  task automatic test_branch();
    exp_t e; logic [17:0] o;
    drain();
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1); cycle("br_lw", 1'b1, Z, Z);
    set_id(1, 5'd6, 1, 5'd6, 1, 5'd7, 1, 0);
    ex_branch_taken = 1'b1;                  cycle("br_over_lu", 1'b1, BRF, BRF);
    ex_branch_taken = 1'b0;
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd8, 1, 0); cycle("br_no_stall", 1'b1, Z, Z);
    while (expq.size() != 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== {e.ea, e.eb}) begin
        errors++;
        $display("FAIL %s: got a=%b b=%b, expected a=%b b=%b", e.tag, o[17:9], o[8:0], e.ea, e.eb);
      end
    end
  endtask

  task automatic test_mem_wait();
    exp_t e; logic [17:0] o;
    drain();
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0); cycle("mw_c1", 1'b1, Z, Z);
    set_id(1, 5'd5, 1, 5'd3, 1, 5'd6, 1, 0); cycle("mw_c2", 1'b1, Z, Z);
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd8, 1, 0);
    ex_branch_taken = 1'b1; mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) cycle($sformatf("mw_hold%0d", i), 1'b1, WAIT_MEM, WAIT_MEM);
    mem_wait = 1'b0;                         cycle("mw_release_flush", 1'b1, BR_MEM, BR_MEM);
    ex_branch_taken = 1'b0;
    while (expq.size() != 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== {e.ea, e.eb}) begin
        errors++;
        $display("FAIL %s: got a=%b b=%b, expected a=%b b=%b", e.tag, o[17:9], o[8:0], e.ea, e.eb);
      end
    end
  endtask

  task automatic test_x0();
    exp_t e; logic [17:0] o;
    drain();
    set_id(1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0); cycle("x0_addi", 1'b1, Z, Z);
    set_id(1, 5'd0, 1, 5'd0, 1, 5'd1, 1, 0); cycle("x0_add", 1'b1, Z, Z);
    set_id(1, 5'd2, 1, 5'd0, 0, 5'd0, 1, 1); cycle("x0_fwd_ex", 1'b1, Z, Z);
    set_id(1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 0); cycle("x0_load_nostall", 1'b1, Z, Z);
    idle_id();                               cycle("x0_after_load", 1'b1, Z, Z);
    while (expq.size() != 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== {e.ea, e.eb}) begin
        errors++;
        $display("FAIL %s: got a=%b b=%b, expected a=%b b=%b", e.tag, o[17:9], o[8:0], e.ea, e.eb);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    exp_t e; logic [17:0] o;
    drain();
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1); cycle("rs_lw", 1'b1, Z, Z);
    set_id(1, 5'd6, 1, 5'd6, 1, 5'd7, 1, 0); cycle("rs_stall", 1'b1, STL, STL);
    rst = 1'b1;                              cycle("rs_assert", 1'b0, Z, Z);
    rst = 1'b0;                              cycle("rs_after_stall", 1'b1, Z, Z);
    drain();
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0); cycle("rw_c1", 1'b1, Z, Z);
    set_id(1, 5'd5, 1, 5'd3, 1, 5'd6, 1, 0);
    mem_wait = 1'b1;                         cycle("rw_wait", 1'b1, WAIT0, WAIT0);
    rst = 1'b1;                              cycle("rw_assert", 1'b0, Z, Z);
    rst = 1'b0; mem_wait = 1'b0; idle_id();  cycle("rw_after_wait", 1'b1, Z, Z);
    while (expq.size() != 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== {e.ea, e.eb}) begin
        errors++;
        $display("FAIL %s: got a=%b b=%b, expected a=%b b=%b", e.tag, o[17:9], o[8:0], e.ea, e.eb);
      end
    end
  endtask

  task automatic test_perf();
    drain();
    rst = 1'b1; cycle("pf_rst", 1'b0, Z, Z);
    rst = 1'b0;
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) cycle("pf_br", 1'b0, Z, Z);
    mem_wait = 1'b1; cycle("pf_br_wait", 1'b0, Z, Z);
    mem_wait = 1'b0; ex_branch_taken = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      set_id(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1); cycle("pf_lw", 1'b0, Z, Z);
      set_id(1, 5'd6, 1, 5'd6, 1, 5'd7, 1, 0); cycle("pf_use", 1'b0, Z, Z);
      cycle("pf_use2", 1'b0, Z, Z);
      if (n == 10) begin
        checks++;
`ifdef HAZARD_PERF_EN
        if (pst_a !== 4'hA || pst_b !== 4'hF) begin
`else
        if (pst_a !== 4'h0 || pst_b !== 4'h0) begin
`endif
          errors++;
          $display("FAIL perf_stall_mid: got a=%h b=%h", pst_a, pst_b);
        end
      end
    end
    idle_id(); cycle("pf_idle", 1'b0, Z, Z);
    checks++;
`ifdef HAZARD_PERF_EN
    if (pst_a !== 4'hF || pst_b !== 4'hF || pfl_a !== 4'd3 || pfl_b !== 4'd3) begin
`else
    if (pst_a !== 4'h0 || pst_b !== 4'h0 || pfl_a !== 4'h0 || pfl_b !== 4'h0) begin
`endif
      errors++;
      $display("FAIL perf_sat: got stall a=%h b=%h flush a=%h b=%h", pst_a, pst_b, pfl_a, pfl_b);
    end
    rst = 1'b1; cycle("pf_rst2", 1'b0, Z, Z);
    rst = 1'b0;
    checks++;
    if (pst_a !== 4'h0 || pst_b !== 4'h0 || pfl_a !== 4'h0 || pfl_b !== 4'h0) begin
      errors++;
      $display("FAIL perf_rst: got stall a=%h b=%h flush a=%h b=%h, required 0", pst_a, pst_b, pfl_a, pfl_b);
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_back_to_back();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_x0();
    test_reset_mid_op();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
